shift_sequencer_6bit: RTL and testbench

- Controller that sequences the team's 6-bit right-shift register (JK flip-flop chain with per-bit preset, common clear, serial input at bit 5, shifting toward bit 0).
- Accepts a start request, then either presets the register with a parallel word or clears it.
- Then gates exactly SHIFT_COUNT shift cycles, captures the register contents and signals completion.
- Sits between a host FSM/testbench and one register instance; the register's clock is gated by shiftEnable at integration.

---
 rtl/shift_sequencer_6bit_pkg.sv | 15 +
 rtl/shift_sequencer_6bit.sv | 146 ++++++++++++++
 tb/tb_shift_sequencer_6bit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_6bit_pkg.sv
// Shared definitions for the 6-bit shift-register sequencer:
// FSM state encoding, register width and counter width.
package shift_sequencer_6bit_pkg;

    localparam int REG_WIDTH = 6;
    localparam int CNT_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        SHIFT   = 2'd2,
        CAPTURE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/shift_sequencer_6bit.sv
// Sequencer for the 6-bit JK right-shift register.
// Accepts a start request, presets or clears the register, gates
// SHIFT_COUNT shift cycles, then captures regOut into result and pulses done.
//
// Optional build macro SHIFT_SEQUENCER_ROTATE_EN: when defined, the register
// serial input is fed from regOut[0] during SHIFT (rotate) and serialIn is
// ignored; when undefined, serialIn is passed through during SHIFT.
//
// Handshake: start is a level request sampled on the rising clock edge and
// is accepted only when busy=0 (IDLE); there is no queueing, and a start
// seen in any other state is dropped. done is a one-cycle pulse in CAPTURE;
// result is valid from the cycle after done and held until the next capture.
module shift_sequencer_6bit
    import shift_sequencer_6bit_pkg::*;
#(
    parameter int WIDTH       = REG_WIDTH,
    parameter int SHIFT_COUNT = 6
) (
    input  logic             clockpulse,
    input  logic             clear,
    input  logic             start,
    input  logic             loadMode,
    input  logic [WIDTH-1:0] loadWord,
    input  logic             serialIn,
    input  logic [WIDTH-1:0] regOut,
    output logic             regClear,
    output logic             regEnablePreset,
    output logic [WIDTH-1:0] regPreset,
    output logic             regSerialInput,
    output logic             shiftEnable,
    output logic             serialOut,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output seq_state_e       dbg_state
);

    // Counter value of the final SHIFT cycle; the counter stops here.
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(SHIFT_COUNT - 1);

    seq_state_e             state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic                   accept;

    // Registered output strobes. The preset word and the clear/preset
    // choice are captured here at accept, so they also act as the latched
    // copy of loadMode/loadWord for the single LOAD cycle.
    logic                   reg_clear_q, reg_clear_d;
    logic                   preset_en_q, preset_en_d;
    logic [WIDTH-1:0]       preset_q, preset_d;
    logic                   shift_en_q, shift_en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    // Next-state, counter, capture and registered-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        accept      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CAPTURE: begin
                result_d = regOut;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the state being
        // entered. LOAD is only reachable through accept, so the clear or
        // preset strobe follows the loadMode/loadWord seen at accept.
        reg_clear_d = accept & ~loadMode;
        preset_en_d = accept & loadMode;
        preset_d    = (accept & loadMode) ? loadWord : '0;
        shift_en_d  = (state_d == SHIFT);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == CAPTURE);
    end

    // State, counter, result and output registers; clear aborts to IDLE.
    always_ff @(posedge clockpulse or posedge clear) begin
        if (clear) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            result_q    <= '0;
            reg_clear_q <= 1'b1;
            preset_en_q <= 1'b0;
            preset_q    <= '0;
            shift_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            reg_clear_q <= reg_clear_d;
            preset_en_q <= preset_en_d;
            preset_q    <= preset_d;
            shift_en_q  <= shift_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign regClear        = reg_clear_q;
    assign regEnablePreset = preset_en_q;
    assign regPreset       = preset_q;
    assign shiftEnable     = shift_en_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign result          = result_q;
    assign dbg_state       = state_q;

    // Serial paths are combinational and forced low outside SHIFT.
    assign serialOut = (state_q == SHIFT) ? regOut[0] : 1'b0;

`ifdef SHIFT_SEQUENCER_ROTATE_EN
    logic unused_serial_in;
    assign unused_serial_in = serialIn;
    assign regSerialInput   = (state_q == SHIFT) ? regOut[0] : 1'b0;
`else
    assign regSerialInput   = (state_q == SHIFT) ? serialIn : 1'b0;
`endif

endmodule

// File: tb/tb_shift_sequencer_6bit.sv
// Bench for shift_sequencer_6bit: drives operations, models the 6-bit JK
// register the sequencer controls, and scoreboards done timing, result and
// the serialOut stream against a word-level reference model.
module tb_shift_sequencer_6bit;
    import shift_sequencer_6bit_pkg::*;

    localparam int W  = 6;
    localparam int SC = 6;

    logic         clockpulse = 1'b0;
    logic         clear = 1'b1;
    logic         start = 1'b0;
    logic         loadMode = 1'b0;
    logic [W-1:0] loadWord = '0;
    logic         serialIn = 1'b0;
    logic [W-1:0] regOut;
    logic         regClear, regEnablePreset, regSerialInput, shiftEnable;
    logic         serialOut, busy, done;
    logic [W-1:0] regPreset, result;
    seq_state_e   dbg_state;

    shift_sequencer_6bit #(.WIDTH(W), .SHIFT_COUNT(SC)) dut (
        .clockpulse(clockpulse), .clear(clear), .start(start),
        .loadMode(loadMode), .loadWord(loadWord), .serialIn(serialIn),
        .regOut(regOut), .regClear(regClear),
        .regEnablePreset(regEnablePreset), .regPreset(regPreset),
        .regSerialInput(regSerialInput), .shiftEnable(shiftEnable),
        .serialOut(serialOut), .busy(busy), .done(done), .result(result),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clockpulse = ~clockpulse;

    int cyc = 0;
    always @(posedge clockpulse) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Register under control: async common clear, per-bit preset (sets the
    // bits that are 1), shifts toward bit 0 only when its clock is enabled.
    logic [W-1:0] shreg = '0;
    always @(posedge clockpulse or posedge regClear) begin
        if (regClear)             shreg <= '0;
        else if (regEnablePreset) shreg <= shreg | regPreset;
        else if (shiftEnable)     shreg <= {regSerialInput, shreg[W-1:1]};
    end
    assign regOut = shreg;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    logic         ser_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    logic         cap_pending = 1'b0;
    logic [W-1:0] cap_exp;

    // Monitor: pops expectations whenever the DUT presents done or shifts.
    always @(negedge clockpulse) begin
        if (cap_pending) begin
            chk("result_after_done", result, cap_exp);
            chk("done_single_cycle", done, 0);
            cap_pending = 1'b0;
        end
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation at %0t", $time);
            end else begin
                cap_exp = exp_q.pop_front();
                chk("done_latency_cycle", cyc, exp_cyc_q.pop_front());
                cap_pending = 1'b1;
            end
        end
        if (shiftEnable) begin
            if (ser_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_shift: got shiftEnable=1 expected idle at %0t", $time);
            end else begin
                chk("serialOut", serialOut, ser_q.pop_front());
            end
        end
        if (!clear) chk("preset_clear_exclusive", regEnablePreset & regClear, 0);
    end

    // ---------------- reference model ----------------
    // Register contents as a word; an operation starts from the preset
    // (OR onto the held word) or zero, then shifts SC bits in from the top.
    logic [W-1:0] model_reg = '0;

    task automatic model_op(input logic mode, input logic [W-1:0] word,
                            input logic [W-1:0] bits,
                            output logic [W-1:0] res, output logic [W-1:0] ser);
        int r;
        int in_bit;
        r = mode ? int'(model_reg | word) : 0;
        ser = '0;
        for (int k = 0; k < SC; k++) begin
            ser[k] = r[0];
`ifdef SHIFT_SEQUENCER_ROTATE_EN
            in_bit = r % 2;
`else
            in_bit = int'(bits[k]);
`endif
            r = (r / 2) + in_bit * 32;
        end
        res = W'(r);
    endtask

    // ---------------- driver ----------------
    // Called at a negedge with the DUT idle; returns at a negedge with the
    // DUT idle again. inject_k asserts a stray start in SHIFT cycle k;
    // abort_k asserts clear in SHIFT cycle k.
    task automatic do_op(input logic mode, input logic [W-1:0] word,
                         input logic [W-1:0] bits, input int inject_k,
                         input int abort_k);
        logic [W-1:0] res, ser;
        model_op(mode, word, bits, res, ser);
        start    = 1'b1;
        loadMode = mode;
        loadWord = word;
        exp_q.push_back(res);
        exp_cyc_q.push_back(cyc + SC + 2);
        for (int k = 0; k < SC; k++) ser_q.push_back(ser[k]);
        @(negedge clockpulse);
        start    = 1'b0;
        loadWord = W'($urandom);
        loadMode = 1'($urandom_range(0, 1));
        for (int k = 0; k < SC; k++) begin
            @(negedge clockpulse);
            if (k == abort_k) begin
                #2 clear = 1'b1;
                #1;
                chk("abort_busy", busy, 0);
                chk("abort_result", result, 0);
                chk("abort_done", done, 0);
                chk("abort_shift_en", shiftEnable, 0);
                chk("abort_reg_clear", regClear, 1);
                exp_q.delete();
                exp_cyc_q.delete();
                ser_q.delete();
                model_reg = '0;
                @(negedge clockpulse);
                clear = 1'b0;
                start = 1'b0;
                return;
            end
            serialIn = bits[k];
            if (k == inject_k) begin
                start    = 1'b1;
                loadWord = '1;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clockpulse);
        chk("busy_in_capture", busy, 1);
        serialIn = 1'($urandom_range(0, 1));
        start    = 1'($urandom_range(0, 1));
        loadWord = W'($urandom);
        @(negedge clockpulse);
        start = 1'b0;
        chk("idle_not_busy", busy, 0);
        model_reg = res;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(negedge clockpulse);
        chk("reset_busy", busy, 0);
        chk("reset_result", result, 0);
        chk("reset_done", done, 0);
        chk("reset_reg_clear", regClear, 1);
        chk("reset_reg_out", regOut, 0);
        chk("reset_preset_en", regEnablePreset, 0);
        chk("reset_preset", regPreset, 0);
        chk("reset_shift_en", shiftEnable, 0);
        chk("reset_serial_in", regSerialInput, 0);
        clear = 1'b0;

        do_op(1'b1, 6'b101101, 6'b000000, -1, -1);
        do_op(1'b0, 6'b000000, 6'b010011, -1, -1);
        do_op(1'b1, 6'b001010, W'($urandom), 2, -1);
        do_op(1'b1, W'($urandom), W'($urandom), -1, 2);
        do_op(1'b0, W'($urandom), W'($urandom), -1, -1);
        do_op(1'b1, 6'b100110, 6'b101010, -1, -1);

        for (int i = 0; i < 24; i++) begin
            int inj, abt;
            inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, SC - 1)) : -1;
            abt = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, SC - 1)) : -1;
            do_op(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), inj, abt);
        end

        repeat (3) @(negedge clockpulse);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("serial_drained", ser_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
